// File: rtl/guess_capture_if.sv
// guess_capture_if: guess handshake between the capture front end and the game FSM
//   enable       consumer is accepting guesses
//   guess_ready  consumer takes guess_bits this cycle
//   guess_valid  guess_bits holds a captured guess
//   guess_bits   switch pattern captured at press
//   armed        front end is ready; next press is captured
//   sw_clear     synchronised switches are all 0
interface guess_capture_if #(parameter int WIDTH = 5);
  logic             enable;
  logic             guess_ready;
  logic             guess_valid;
  logic [WIDTH-1:0] guess_bits;
  logic             armed;
  logic             sw_clear;
  modport master (output enable, guess_ready, input guess_valid, guess_bits, armed, sw_clear);
  modport slave  (input enable, guess_ready, output guess_valid, guess_bits, armed, sw_clear);
endinterface

// File: rtl/guess_capture.sv
// guess_capture: synchronises and debounces the guess key, emits one held guess per clean press
//   CLOCK_50  system clock
//   resetN    asynchronous active-low reset
//   key_n     raw guess key, active-low, asynchronous
//   sw        raw guess switches, asynchronous
//   gif       guess handshake (slave side)
module guess_capture #(
  parameter int WIDTH           = 5,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic             CLOCK_50,
  input  logic             resetN,
  input  logic             key_n,
  input  logic [WIDTH-1:0] sw,
  guess_capture_if.slave   gif
);
  typedef enum logic [1:0] {ARM, READY, HOLD, WAIT_REL} state_t;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  state_t           state_q, state_d;
  logic             key_s1_q, key_s1_d, key_s2_q, key_s2_d;
  logic [WIDTH-1:0] sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
  logic             deb_q, deb_d, deb_prev_q, deb_prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       start_q, start_d;
  logic             valid_q, valid_d, armed_q, armed_d;
  logic [WIDTH-1:0] bits_q, bits_d;
  logic             flip, press, sw_clear;
  assign sw_clear        = sw_s2_q == '0;
  assign gif.sw_clear    = sw_clear;
  assign gif.guess_valid = valid_q;
  assign gif.guess_bits  = bits_q;
  assign gif.armed       = armed_q;
  always_comb begin
    key_s1_d   = key_n;
    key_s2_d   = key_s1_q;
    sw_s1_d    = sw;
    sw_s2_d    = sw_s1_q;
    start_d    = {start_q[0], 1'b1};
    flip       = (key_s2_q != deb_q) && (cnt_q == CNT_LAST);
    cnt_d      = (key_s2_q == deb_q || flip) ? '0 : cnt_q + 1'b1;
    deb_d      = flip ? key_s2_q : deb_q;
    deb_prev_d = deb_q;
    press      = deb_prev_q & ~deb_q;
    state_d    = state_q;
    bits_d     = bits_q;
    case (state_q)
      // Arming waits until the sync chain holds real samples and the raw key reads released,
      // so a key held down through reset is never mistaken for a fresh press.
      ARM:      if (start_q[1] && key_s2_q && deb_q && sw_clear && gif.enable) state_d = READY;
      READY:    if (!gif.enable) state_d = ARM;
                else if (press) begin
                  state_d = HOLD;
                  bits_d  = sw_s2_q;
                end
      HOLD:     if (gif.guess_ready || !gif.enable) state_d = WAIT_REL;
      WAIT_REL: if (deb_q) state_d = ARM;
      default:  state_d = ARM;
    endcase
    valid_d = state_d == HOLD;
    armed_d = state_d == READY;
  end
  always_ff @(posedge CLOCK_50 or negedge resetN) begin
    if (!resetN) begin
      key_s1_q   <= 1'b1;
      key_s2_q   <= 1'b1;
      sw_s1_q    <= '0;
      sw_s2_q    <= '0;
      deb_q      <= 1'b1;
      deb_prev_q <= 1'b1;
      cnt_q      <= '0;
      start_q    <= '0;
      state_q    <= ARM;
      valid_q    <= 1'b0;
      armed_q    <= 1'b0;
      bits_q     <= '0;
    end else begin
      key_s1_q   <= key_s1_d;
      key_s2_q   <= key_s2_d;
      sw_s1_q    <= sw_s1_d;
      sw_s2_q    <= sw_s2_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      cnt_q      <= cnt_d;
      start_q    <= start_d;
      state_q    <= state_d;
      valid_q    <= valid_d;
      armed_q    <= armed_d;
      bits_q     <= bits_d;
    end
  end
endmodule

// File: tb/tb_guess_capture.sv
// tb_guess_capture: randomized self-checking bench for guess_capture with a 4-cycle debounce
module tb_guess_capture;
  localparam int W   = 5;
  localparam int D   = 4;
  localparam int LAT = 2 + D + 1;
  logic         clk = 1'b0;
  logic         resetN = 1'b0;
  logic         key_n = 1'b1;
  logic [W-1:0] sw = '0;
  int           ck = 0;
  int           er = 0;
  guess_capture_if #(.WIDTH(W)) gif ();
  guess_capture #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .CNT_W(20)) dut (
    .CLOCK_50(clk), .resetN(resetN), .key_n(key_n), .sw(sw), .gif(gif)
  );
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_armed(output int n);
    n = 0;
    while (!gif.armed && n < 60) begin
      tick();
      n++;
    end
  endtask

  // Press the key with a switch pattern and count cycles until guess_valid (bounded).
  task automatic press_get(input logic [W-1:0] pat, output int lat);
    key_n = 1'b0;
    sw    = pat;
    lat   = 0;
    while (!gif.guess_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic accept();
    gif.guess_ready = 1'b1;
    tick();
    gif.guess_ready = 1'b0;
  endtask

  task automatic release_key(input string nm);
    int n;
    key_n = 1'b1;
    sw    = '0;
    wait_armed(n);
    ck++;
    if (gif.armed !== 1'b1) begin
      er++;
      $display("FAIL %s_rearm: armed=%b required 1 within 60 cycles", nm, gif.armed);
    end
  endtask

  task automatic test_reset();
    int n;
    resetN = 1'b0;
    gif.enable = 1'b1;
    gif.guess_ready = 1'b0;
    #12;
    ck += 4;
    if (gif.guess_valid !== 1'b0) begin er++; $display("FAIL reset_valid: got %b required 0", gif.guess_valid); end
    if (gif.guess_bits !== '0) begin er++; $display("FAIL reset_bits: got %b required 00000", gif.guess_bits); end
    if (gif.armed !== 1'b0) begin er++; $display("FAIL reset_armed: got %b required 0", gif.armed); end
    if (gif.sw_clear !== 1'b1) begin er++; $display("FAIL reset_sw_clear: got %b required 1", gif.sw_clear); end
    @(negedge clk);
    resetN = 1'b1;
    wait_armed(n);
    ck++;
    if (gif.armed !== 1'b1) begin er++; $display("FAIL reset_arm: armed=%b required 1", gif.armed); end
  endtask

  task automatic test_latency();
    int lat;
    bit extra;
    press_get(5'b10110, lat);
    ck += 3;
    if (lat != LAT) begin er++; $display("FAIL lat_cycles: got %0d required %0d", lat, LAT); end
    if (gif.guess_bits !== 5'b10110) begin er++; $display("FAIL lat_bits: got %b required 10110", gif.guess_bits); end
    if (gif.armed !== 1'b0) begin er++; $display("FAIL lat_armed: got %b required 0", gif.armed); end
    accept();
    extra = 0;
    repeat (20) begin
      tick();
      if (gif.guess_valid) extra = 1;
    end
    ck++;
    if (extra) begin er++; $display("FAIL lat_second_guess: got valid during held key, required none"); end
    release_key("lat");
  endtask

  task automatic test_glitch();
    bit seen, deb_low;
    for (int l = 1; l < D; l++) begin
      key_n = 1'b0;
      repeat (l) tick();
      key_n = 1'b1;
      seen = 0;
      deb_low = 0;
      repeat (15) begin
        tick();
        if (gif.guess_valid) seen = 1;
        if (dut.deb_q !== 1'b1) deb_low = 1;
      end
      ck += 3;
      if (seen) begin er++; $display("FAIL glitch%0d_valid: got guess required none", l); end
      if (deb_low) begin er++; $display("FAIL glitch%0d_deb: debounced key went 0 required 1", l); end
      if (gif.armed !== 1'b1) begin er++; $display("FAIL glitch%0d_armed: got %b required 1", l, gif.armed); end
    end
  endtask

  task automatic test_hold();
    int lat;
    bit extra;
    logic [W-1:0] pat;
    pat = W'($urandom_range(1, 31));
    press_get(pat, lat);
    ck++;
    if (lat != LAT) begin er++; $display("FAIL hold_lat: got %0d required %0d", lat, LAT); end
    for (int i = 0; i < 10; i++) begin
      sw = W'($urandom);
      tick();
      ck++;
      if (gif.guess_valid !== 1'b1 || gif.guess_bits !== pat)
        begin er++; $display("FAIL hold_stable%0d: valid=%b bits=%b required 1/%b", i, gif.guess_valid, gif.guess_bits, pat); end
    end
    accept();
    ck++;
    if (gif.guess_valid !== 1'b0) begin er++; $display("FAIL hold_drop: valid=%b required 0", gif.guess_valid); end
    extra = 0;
    repeat (20) begin
      tick();
      if (gif.guess_valid) extra = 1;
    end
    ck++;
    if (extra) begin er++; $display("FAIL hold_second: got second guess required none"); end
    release_key("hold");
  endtask

  task automatic test_rearm_sw();
    int lat, n;
    bit seen;
    press_get(5'b00111, lat);
    accept();
    key_n = 1'b1;
    sw = 5'b00001;
    repeat (20) tick();
    ck++;
    if (gif.armed !== 1'b0) begin er++; $display("FAIL sw_block_armed: got %b required 0", gif.armed); end
    key_n = 1'b0;
    seen = 0;
    repeat (15) begin
      tick();
      if (gif.guess_valid) seen = 1;
    end
    key_n = 1'b1;
    repeat (15) tick();
    ck++;
    if (seen) begin er++; $display("FAIL sw_block_guess: got guess required none"); end
    sw = '0;
    wait_armed(n);
    ck++;
    if (gif.armed !== 1'b1) begin er++; $display("FAIL sw_clear_arm: armed=%b required 1", gif.armed); end
    press_get(5'b01000, lat);
    ck += 2;
    if (lat != LAT) begin er++; $display("FAIL sw_rearm_lat: got %0d required %0d", lat, LAT); end
    if (gif.guess_bits !== 5'b01000) begin er++; $display("FAIL sw_rearm_bits: got %b required 01000", gif.guess_bits); end
    accept();
    release_key("sw");
  endtask

  task automatic test_enable_drop();
    int lat;
    bit seen;
    press_get(5'b11001, lat);
    gif.enable = 1'b0;
    tick();
    ck++;
    if (gif.guess_valid !== 1'b0) begin er++; $display("FAIL en_discard: valid=%b required 0", gif.guess_valid); end
    gif.enable = 1'b1;
    seen = 0;
    repeat (15) begin
      tick();
      if (gif.guess_valid) seen = 1;
    end
    ck++;
    if (seen) begin er++; $display("FAIL en_requeue: got guess required none"); end
    release_key("en1");
    press_get(5'b00110, lat);
    ck++;
    if (gif.guess_bits !== 5'b00110) begin er++; $display("FAIL en_race_bits: got %b required 00110", gif.guess_bits); end
    gif.guess_ready = 1'b1;
    gif.enable = 1'b0;
    tick();
    gif.guess_ready = 1'b0;
    gif.enable = 1'b1;
    ck++;
    if (gif.guess_valid !== 1'b0) begin er++; $display("FAIL en_race_drop: valid=%b required 0", gif.guess_valid); end
    release_key("en2");
  endtask

  task automatic test_async_reset();
    int lat;
    bit seen;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) press_get(5'b10101, lat);
      else begin
        key_n = 1'b0;
        sw = 5'b00011;
        repeat (3) tick();
      end
      #2 resetN = 1'b0;
      #1;
      ck += 2;
      if (gif.guess_valid !== 1'b0) begin er++; $display("FAIL areset%0d_valid: got %b required 0", k, gif.guess_valid); end
      if (gif.armed !== 1'b0) begin er++; $display("FAIL areset%0d_armed: got %b required 0", k, gif.armed); end
      @(negedge clk);
      resetN = 1'b1;
      seen = 0;
      repeat (25) begin
        tick();
        if (gif.guess_valid) seen = 1;
      end
      ck++;
      if (seen) begin er++; $display("FAIL areset%0d_held_key: got guess required none", k); end
      release_key("areset");
      press_get(5'b11110, lat);
      ck += 2;
      if (lat != LAT) begin er++; $display("FAIL areset%0d_lat: got %0d required %0d", k, lat, LAT); end
      if (gif.guess_bits !== 5'b11110) begin er++; $display("FAIL areset%0d_bits: got %b required 11110", k, gif.guess_bits); end
      accept();
      release_key("areset");
    end
  endtask

  // Reference model: a raw press of len cycles yields exactly one guess, LAT cycles after it starts,
  // iff len >= D; the guess carries the switch pattern held at the press.
  task automatic test_random();
    logic [W-1:0] pat;
    int len, first, wait_rdy, exp_first;
    bit stable;
    for (int it = 0; it < 16; it++) begin
      pat = W'($urandom_range(1, 31));
      len = $urandom_range(1, 2 * D);
      exp_first = (len >= D) ? LAT : 0;
      sw = pat;
      first = 0;
      for (int c = 1; c <= LAT + 4; c++) begin
        key_n = (c > len);
        tick();
        if (gif.guess_valid && first == 0) first = c;
      end
      ck++;
      if (first != exp_first) begin er++; $display("FAIL rnd%0d_first: len=%0d got %0d required %0d", it, len, first, exp_first); end
      if (exp_first != 0) begin
        wait_rdy = $urandom_range(0, 5);
        stable = 1;
        repeat (wait_rdy) begin
          tick();
          if (gif.guess_bits !== pat || !gif.guess_valid) stable = 0;
        end
        ck += 2;
        if (!stable || gif.guess_bits !== pat) begin er++; $display("FAIL rnd%0d_bits: got %b required %b", it, gif.guess_bits, pat); end
        accept();
        if (gif.guess_valid !== 1'b0) begin er++; $display("FAIL rnd%0d_drop: valid=%b required 0", it, gif.guess_valid); end
      end
      release_key("rnd");
    end
  endtask

  initial begin
    gif.enable = 1'b1;
    gif.guess_ready = 1'b0;
    test_reset();
    test_latency();
    test_glitch();
    test_hold();
    test_rearm_sw();
    test_enable_drop();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", ck, er);
    $finish;
  end
endmodule
